pot_scan_sched: RTL and testbench
=================================

POT_SCAN_SCHED -- requirements
Module: pot_scan_sched

Interface
REQ-001 SHALL have parameter SCAN_GAP, default 50000, meaning idle clocks between the end of one scan and the start of the next.
REQ-002 SHALL have parameter CNV_TMO, default 1024, meaning max clocks to wait for cnv_cmplt before abandoning a conversion.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port err_clr  input  1  clears tmo_err.
REQ-007 SHALL have port cnv_cmplt  input  1  conversion-complete pulse from the A2D interface.
REQ-008 SHALL have port res  input  12  conversion result; valid while cnv_cmplt=1.
REQ-009 SHALL have port strt_cnv  output  1  start-conversion pulse to the A2D interface.
REQ-010 SHALL have port chnnl  output  3  A2D channel select.
REQ-011 SHALL have ports LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, volume  output  12 each  published pot values.
REQ-012 SHALL have port scan_done  output  1  one-cycle strobe when the outputs update.
REQ-013 SHALL have port tmo_err  output  1  sticky conversion-timeout flag.

Function
REQ-014 SHALL scan slots 0..5 in fixed order LP, B1, B2, B3, HP, volume, mapped to chnnl values 1, 0, 4, 2, 3, 7.
REQ-015 SHALL implement FSM states IDLE, START, WAIT, GAP.
REQ-016 In IDLE, SHALL set slot=0 and go to START on the first cycle with en=1.
REQ-017 In START, SHALL assert strt_cnv for exactly one cycle, with chnnl already driving the current slot's channel, and then go to WAIT.
REQ-018 SHALL hold chnnl stable from START until the WAIT exit.
REQ-019 In WAIT, SHALL count clocks with a timer cleared on entry; cnv_cmplt=1 SHALL capture res into the current slot's shadow register on that edge.
REQ-020 If cnv_cmplt is not seen when the timer reaches CNV_TMO-1, SHALL set tmo_err, leave that shadow register unchanged, and treat the slot as complete.
REQ-021 On slot completion with slot<5 and en=1, SHALL increment slot and go to START on the next cycle.
REQ-022 On completion of slot 5, SHALL copy all six shadow registers to the outputs simultaneously and pulse scan_done for one cycle.
REQ-023 After the REQ-022 update, SHALL go to GAP, or to IDLE if en=0.
REQ-024 On a REQ-022 update, outputs SHALL change exactly one cycle after the edge on which cnv_cmplt (or the timeout) for slot 5 is sampled.
REQ-025 Outputs SHALL never change at any other time.
REQ-026 GAP SHALL last exactly SCAN_GAP cycles, then go to START with slot=0 if en=1, else to IDLE.
REQ-027 If en falls mid-scan, the conversion in flight SHALL complete and be stored to shadow, outputs SHALL NOT update, the FSM SHALL return to IDLE, and the next scan SHALL restart at slot 0.
REQ-028 SHALL ignore cnv_cmplt in IDLE, START and GAP.
REQ-029 A cnv_cmplt arriving in the same cycle as the timeout SHALL count as success: res is stored and tmo_err is not set.
REQ-030 tmo_err SHALL clear on err_clr=1 only; a simultaneous set and err_clr SHALL leave tmo_err set.
REQ-031 The WAIT timer and GAP counter SHALL be sized for their parameters and SHALL NOT wrap.

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL enter IDLE with slot=0, timers=0, shadows=0.
REQ-033 Reset values SHALL be: all gain outputs and volume 12'h000, strt_cnv=0, chnnl=3'd1, scan_done=0, tmo_err=0.
REQ-034 Reset asserted mid-WAIT SHALL abort the conversion with no store; a later cnv_cmplt SHALL be ignored.
REQ-035 rst_n SHALL have no effect between clock edges.

Verification
REQ-036 Full scan: en=1, model answers each strt_cnv after 20 clocks with res 0x111..0x666 -> chnnl sequence 1,0,4,2,3,7 with one strt_cnv per slot; outputs LP=0x111..volume=0x666 and scan_done both appear 1 cycle after the 6th cnv_cmplt; the next strt_cnv follows SCAN_GAP cycles later.
REQ-037 Timeout: model never answers slot 2 -> tmo_err=1 after CNV_TMO cycles in WAIT; B2_gain keeps its previous value; the scan completes; err_clr then clears tmo_err.
REQ-038 Simultaneous: cnv_cmplt arrives in the timeout cycle with res=0xABC -> value stored, tmo_err stays 0.
REQ-039 en dropped during slot 3 -> slot 3 completes; no scan_done; outputs unchanged; IDLE reached; re-enable -> first strt_cnv has chnnl=1.
REQ-040 Reset during WAIT, followed by a stray cnv_cmplt -> all outputs 0, chnnl=1, no store, no strt_cnv while en=0.

Source files
------------

// File: rtl/pot_scan_sched.sv
// pot_scan_sched: sequences six A2D pot conversions and publishes them atomically per scan.
module pot_scan_sched #(
  parameter int SCAN_GAP = 50000,
  parameter int CNV_TMO = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        err_clr,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP_gain,
  output logic [11:0] B1_gain,
  output logic [11:0] B2_gain,
  output logic [11:0] B3_gain,
  output logic [11:0] HP_gain,
  output logic [11:0] volume,
  output logic        scan_done,
  output logic        tmo_err
);
  localparam int TW = $clog2(CNV_TMO + 1);
  localparam int GW = $clog2(SCAN_GAP + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gcnt;
  logic [2:0] slot;
  logic [5:0][11:0] shd, pots;
  logic pub, tmo_hit, slot_done;
  assign tmo_hit = state == WAIT && tmr == TW'(CNV_TMO - 1) && !cnv_cmplt;
  assign slot_done = state == WAIT && (cnv_cmplt || tmo_hit);
  assign strt_cnv = state == START;
  assign {volume, HP_gain, B3_gain, B2_gain, B1_gain, LP_gain} = pots;
  always_comb begin
    chnnl = slot == 3'd0 ? 3'd1 : slot == 3'd1 ? 3'd0 : slot == 3'd2 ? 3'd4 :
            slot == 3'd3 ? 3'd2 : slot == 3'd4 ? 3'd3 : 3'd7;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = en ? START : IDLE;
      START: nxt = WAIT;
      WAIT:  nxt = !slot_done ? WAIT : !en ? IDLE : slot == 3'd5 ? GAP : START;
      GAP:   nxt = gcnt != GW'(SCAN_GAP - 1) ? GAP : en ? START : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      gcnt <= '0;
      slot <= '0;
      shd <= '0;
      pots <= '0;
      pub <= 1'b0;
      scan_done <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      state <= nxt;
      tmr <= state == WAIT ? tmr + TW'(1) : '0;
      gcnt <= state == GAP ? gcnt + GW'(1) : '0;
      if (slot_done) slot <= (slot == 3'd5 || !en) ? 3'd0 : slot + 3'd1;
      if (state == WAIT && cnv_cmplt) shd[slot] <= res;
      // publish one cycle later so the slot-5 result is already in shadow
      pub <= slot_done && slot == 3'd5;
      scan_done <= pub;
      if (pub) pots <= shd;
      tmo_err <= tmo_hit | (tmo_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_pot_scan_sched.sv
// tb_pot_scan_sched: table-driven scans against an A2D responder plus en-drop and reset sequences.
module tb_pot_scan_sched;
  localparam int GAP = 10;
  localparam int TMO = 32;
  localparam logic [7:0] NA = 8'hFF;
  typedef struct packed {
    logic [5:0][7:0] dly;
    logic [5:0][11:0] val;
    logic [5:0][11:0] exp;
    logic tmo;
  } rec_t;
  logic clk = 0, rst_n = 0, en = 0, err_clr = 0, cnv_cmplt = 0;
  logic [11:0] res = '0;
  logic strt_cnv, scan_done, tmo_err;
  logic [2:0] chnnl;
  logic [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, volume;
  int cyc = 0, nchk = 0, nbad = 0, nsc = 0, ndone = 0, k = 0, last_cc = 0, first_sc = 0;
  bit stray = 0;
  logic [2:0] chlog [8];
  logic [5:0][11:0] prev = '0;
  rec_t cur, tbl [4], ra, rb, rn, rc;
  wire [71:0] outs = {volume, HP_gain, B3_gain, B2_gain, B1_gain, LP_gain};

  pot_scan_sched #(.SCAN_GAP(GAP), .CNV_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr), .cnv_cmplt(cnv_cmplt), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .LP_gain(LP_gain), .B1_gain(B1_gain), .B2_gain(B2_gain),
    .B3_gain(B3_gain), .HP_gain(HP_gain), .volume(volume), .scan_done(scan_done), .tmo_err(tmo_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    nsc <= nsc + int'(strt_cnv);
    ndone <= ndone + int'(scan_done);
  end

  function automatic logic [5:0][11:0] v6(input logic [11:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction
  function automatic logic [5:0][7:0] d6(input logic [7:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction
  function automatic int slot_of(input logic [2:0] ch);
    case (ch)
      3'd1: return 0;
      3'd0: return 1;
      3'd4: return 2;
      3'd2: return 3;
      3'd3: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A2D responder: answers each strt_cnv after the delay in the current record
  initial begin
    int s;
    logic [2:0] ch;
    forever begin
      @(negedge clk);
      cnv_cmplt = 0;
      if (stray) begin
        cnv_cmplt = 1;
        res = 12'hFFF;
        stray = 0;
      end
      if (strt_cnv) begin
        ch = chnnl;
        s = slot_of(ch);
        if (k < 8) chlog[k] = ch;
        k++;
        if (s == 0) first_sc = cyc;
        if (cur.dly[s] == NA) last_cc = cyc + TMO;
        else begin
          repeat (int'(cur.dly[s])) @(negedge clk);
          chk("chnnl_hold", 72'(chnnl), 72'(ch));
          cnv_cmplt = 1;
          res = cur.val[s];
          last_cc = cyc;
        end
      end
    end
  end

  task automatic run_scan(input string nm, input rec_t r, input bit gapchk);
    bit got = 0, stable = 1;
    int st = 0, plc = last_cc, ns0 = nsc;
    cur = r;
    k = 0;
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scan_done) begin
        got = 1;
        st = cyc;
        break;
      end
      if (outs !== 72'(prev)) stable = 0;
    end
    chk({nm, "_done_seen"}, 72'(got), 72'd1);
    chk({nm, "_outs_stable"}, 72'(stable), 72'd1);
    chk({nm, "_done_latency"}, 72'(st - last_cc), 72'd2);
    chk({nm, "_outs"}, outs, 72'(r.exp));
    chk({nm, "_tmo_err"}, 72'(tmo_err), 72'(r.tmo));
    chk({nm, "_chnnl_seq"}, 72'({chlog[5], chlog[4], chlog[3], chlog[2], chlog[1], chlog[0]}),
        72'({3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1}));
    chk({nm, "_strt_cycles"}, 72'(nsc - ns0), 72'd6);
    if (gapchk) chk({nm, "_gap"}, 72'(first_sc - plc), 72'(GAP + 1));
    prev = r.exp;
    @(negedge clk);
    chk({nm, "_done_pulse"}, 72'(scan_done), 72'd0);
    if (r.tmo) begin
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      @(negedge clk);
      chk({nm, "_err_clr"}, 72'(tmo_err), 72'd0);
    end
  endtask

  initial begin
    int ns0, nd0;
    bit hit;
    tbl[0] = '{d6(8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20),
               v6(12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666),
               v6(12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666), 1'b0};
    tbl[1] = '{d6(8'd20, 8'd20, NA, 8'd20, 8'd20, 8'd20),
               v6(12'h101, 12'h202, 12'h303, 12'h404, 12'h505, 12'h606),
               v6(12'h101, 12'h202, 12'h333, 12'h404, 12'h505, 12'h606), 1'b1};
    tbl[2] = '{d6(8'd3, 8'd4, 8'd5, 8'd6, 8'd32, 8'd7),
               v6(12'hA01, 12'hA02, 12'hA03, 12'hA04, 12'hABC, 12'hA06),
               v6(12'hA01, 12'hA02, 12'hA03, 12'hA04, 12'hABC, 12'hA06), 1'b0};
    tbl[3] = '{d6(8'd2, 8'd2, 8'd2, 8'd2, 8'd2, NA),
               v6(12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06),
               v6(12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hA06), 1'b1};
    ra = '{d6(8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20),
           v6(12'hC01, 12'hC02, 12'hC03, 12'hC04, 12'hC05, 12'hC06), '0, 1'b0};
    rb = '{d6(8'd5, 8'd5, 8'd5, NA, 8'd5, 8'd5),
           v6(12'hD01, 12'hD02, 12'hD03, 12'hD04, 12'hD05, 12'hD06),
           v6(12'hD01, 12'hD02, 12'hD03, 12'hC04, 12'hD05, 12'hD06), 1'b1};
    rn = '{d6(NA, NA, NA, NA, NA, NA), '0, '0, 1'b0};
    rc = '{d6(NA, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5),
           v6(12'hE01, 12'hE02, 12'hE03, 12'hE04, 12'hE05, 12'hE06),
           v6(12'h000, 12'hE02, 12'hE03, 12'hE04, 12'hE05, 12'hE06), 1'b1};
    cur = rn;
    repeat (3) @(negedge clk);
    chk("rst_outs", outs, 72'd0);
    chk("rst_chnnl", 72'(chnnl), 72'd1);
    chk("rst_strt", 72'(strt_cnv), 72'd0);
    chk("rst_done", 72'(scan_done), 72'd0);
    chk("rst_tmo", 72'(tmo_err), 72'd0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("idle_no_strt", 72'(nsc), 72'd0);
    for (int i = 0; i < 4; i++) run_scan($sformatf("scan%0d", i), tbl[i], i > 0);
    // en dropped while slot 3 converts
    ns0 = nsc;
    nd0 = ndone;
    cur = ra;
    k = 0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = k >= 4;
    end
    chk("endrop_reach_slot3", 72'(hit), 72'd1);
    en = 0;
    repeat (60) @(negedge clk);
    chk("endrop_no_done", 72'(ndone - nd0), 72'd0);
    chk("endrop_outs", outs, 72'(prev));
    chk("endrop_strts", 72'(nsc - ns0), 72'd4);
    chk("endrop_idle_chnnl", 72'(chnnl), 72'd1);
    run_scan("reenable", rb, 1'b0);
    // reset mid-WAIT followed by a stray completion
    cur = rn;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = strt_cnv;
    end
    chk("rstwait_strt_seen", 72'(hit), 72'd1);
    repeat (5) @(negedge clk);
    rst_n = 0;
    en = 0;
    @(negedge clk);
    rst_n = 1;
    stray = 1;
    @(negedge clk);
    ns0 = nsc;
    nd0 = ndone;
    repeat (40) @(negedge clk);
    chk("rstwait_outs", outs, 72'd0);
    chk("rstwait_chnnl", 72'(chnnl), 72'd1);
    chk("rstwait_no_strt", 72'(nsc - ns0), 72'd0);
    chk("rstwait_no_done", 72'(ndone - nd0), 72'd0);
    chk("rstwait_tmo", 72'(tmo_err), 72'd0);
    prev = '0;
    run_scan("after_rst", rc, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
